// File: rtl/cordic_pkg.sv
// Shared CORDIC datapath constants and the result-FIFO operation encoding.
package cordic_pkg;

  localparam int CORDIC_WIDTH      = 32;
  localparam int CORDIC_FIFO_DEPTH = 8;

  // Bit 0 = accepted write, bit 1 = accepted pop.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/cordic_fifo_ram.sv
// Result FIFO storage: DEPTH x WIDTH, one synchronous write port, one async read port.
// Latency: write visible on rd_dat the cycle after the write edge.
// Backpressure: none; the caller gates wr_en.
module cordic_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             HCLK,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge HCLK) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/cordic_result_fifo.sv
// Buffers CORDIC result words for bus-side reads, first-word-fall-through.
// Latency: a word written at edge N is at the head the cycle after edge N.
// Backpressure: none upstream; writes while full are dropped and flagged via overflow.
module cordic_result_fifo
  import cordic_pkg::*;
#(
  parameter int WIDTH = CORDIC_WIDTH,
  parameter int DEPTH = CORDIC_FIFO_DEPTH
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     valid_out_interface,
  input  logic [WIDTH-1:0]         out_interface,
  input  logic                     read_fifo_en,
  input  logic                     clear_flags,
  output logic [WIDTH-1:0]         out_fifo,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] rd_dat;
  logic             wr_acc;
  logic             rd_acc;
  fifo_op_e         op;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign rd_acc = read_fifo_en && !empty;
  assign wr_acc = valid_out_interface && (!full || rd_acc);
  assign op     = fifo_op_e'({rd_acc, wr_acc});

  cordic_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .HCLK    (HCLK),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_dat  (out_interface),
    .rd_addr (rd_ptr),
    .rd_dat  (rd_dat)
  );

  assign out_fifo = empty ? '0 : rd_dat;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);

      case (op)
        OP_PUSH: count <= count + CW'(1);
        OP_POP:  count <= count - CW'(1);
        default: count <= count;
      endcase

      // A new event in the same cycle as clear_flags leaves the flag set.
      if (valid_out_interface && !wr_acc) overflow <= 1'b1;
      else if (clear_flags)               overflow <= 1'b0;

      if (read_fifo_en && empty) underflow <= 1'b1;
      else if (clear_flags)      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cordic_result_fifo.sv
// Directed bench for cordic_result_fifo with a queue scoreboard and flag model.
module tb_cordic_result_fifo;

  localparam int W = 32;
  localparam int D = 8;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          valid_out_interface = 1'b0;
  logic [W-1:0]  out_interface = '0;
  logic          read_fifo_en = 1'b0;
  logic          clear_flags = 1'b0;
  logic [W-1:0]  out_fifo;
  logic          empty;
  logic          full;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] sb[$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  cordic_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .HCLK                (HCLK),
    .HRESET              (HRESET),
    .valid_out_interface (valid_out_interface),
    .out_interface       (out_interface),
    .read_fifo_en        (read_fifo_en),
    .clear_flags         (clear_flags),
    .out_fifo            (out_fifo),
    .empty               (empty),
    .full                (full),
    .count               (count),
    .overflow            (overflow),
    .underflow           (underflow)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    logic [W-1:0] head;
    head = (sb.size() == 0) ? '0 : sb[0];
    chk({tag, ".count"},     {28'd0, count},     sb.size());
    chk({tag, ".empty"},     {31'd0, empty},     {31'd0, sb.size() == 0});
    chk({tag, ".full"},      {31'd0, full},      {31'd0, sb.size() == D});
    chk({tag, ".overflow"},  {31'd0, overflow},  {31'd0, m_ovf});
    chk({tag, ".underflow"}, {31'd0, underflow}, {31'd0, m_unf});
    chk({tag, ".head"},      out_fifo,           head);
  endtask

  // One clock cycle: drive, compare popped word pre-edge, update model, compare state post-edge.
  task automatic step(input string tag, input logic wr, input logic [W-1:0] d,
                      input logic rd, input logic clr);
    logic m_empty, m_full, rd_acc, wr_acc;
    valid_out_interface = wr;
    out_interface       = d;
    read_fifo_en        = rd;
    clear_flags         = clr;
    m_empty = (sb.size() == 0);
    m_full  = (sb.size() == D);
    rd_acc  = rd && !m_empty;
    wr_acc  = wr && (!m_full || rd_acc);
    if (rd_acc) chk({tag, ".pop"}, out_fifo, sb[0]);
    @(posedge HCLK);
    #1;
    if (rd_acc) void'(sb.pop_front());
    if (wr_acc) sb.push_back(d);
    if (wr && !wr_acc) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (rd && m_empty) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
    valid_out_interface = 1'b0;
    read_fifo_en        = 1'b0;
    clear_flags         = 1'b0;
    chk_state(tag);
  endtask

  // Reset with write and pop requests held high to show reset dominates.
  task automatic do_reset(input string tag);
    HRESET              = 1'b1;
    valid_out_interface = 1'b1;
    out_interface       = 32'hFFFF_0000;
    read_fifo_en        = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET              = 1'b0;
    valid_out_interface = 1'b0;
    read_fifo_en        = 1'b0;
    sb.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    chk_state(tag);
  endtask

  initial begin
    // Reset state
    @(posedge HCLK);
    do_reset("reset");

    // Three words in, three out, in order
    step("w3", 1'b1, 32'h1111_1111, 1'b0, 1'b0);
    step("w3", 1'b1, 32'h2222_2222, 1'b0, 1'b0);
    step("w3", 1'b1, 32'h3333_3333, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("p3", 1'b0, '0, 1'b1, 1'b0);

    // Nine writes into eight slots: ninth dropped, overflow set
    for (int i = 0; i < 9; i++) step("ovf_w", 1'b1, 32'h0B00_0000 + i, 1'b0, 1'b0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 8; i++) step("ovf_p", 1'b0, '0, 1'b1, 1'b0);
    step("ovf_clr", 1'b0, '0, 1'b0, 1'b1);

    // Pop while empty, clear, and event-wins-over-clear
    step("unf", 1'b0, '0, 1'b1, 1'b0);
    step("unf_idle", 1'b0, '0, 1'b0, 1'b0);
    step("unf_clr", 1'b0, '0, 1'b0, 1'b1);
    step("unf_vs_clr", 1'b0, '0, 1'b1, 1'b1);
    step("unf_clr2", 1'b0, '0, 1'b0, 1'b1);
    // Write and pop while empty: write taken, pop ignored
    step("wr_rd_empty", 1'b1, 32'h5A5A_0001, 1'b1, 1'b0);
    step("wr_rd_empty_p", 1'b0, '0, 1'b1, 1'b1);

    // Full FIFO with simultaneous write and pop
    for (int i = 0; i < 8; i++) step("fill", 1'b1, 32'h0F00_0000 + i, 1'b0, 1'b0);
    step("full_wr_rd", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("full_wr_rd.ovf0", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 7; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    chk("deadbeef_last", out_fifo, 32'hDEAD_BEEF);
    step("drain8", 1'b0, '0, 1'b1, 1'b0);

    // Mid-operation reset discards queued words
    for (int i = 0; i < 5; i++) step("pre_rst_w", 1'b1, 32'h0C00_0000 + i, 1'b0, 1'b0);
    step("pre_rst_p", 1'b0, '0, 1'b1, 1'b0);
    step("pre_rst_p", 1'b0, '0, 1'b1, 1'b0);
    do_reset("mid_reset");
    step("post_rst_w", 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    chk("post_rst_head", out_fifo, 32'hA5A5_A5A5);

    // Interleaved traffic across pointer wrap
    for (int i = 0; i < 20; i++) begin
      step("mix", (i % 3) != 2, 32'hC000_0000 + i, (i % 2) == 1, 1'b0);
      chk("mix.cnt_le8", {31'd0, count <= 4'd8}, 32'd1);
    end
    while (sb.size() != 0) step("mix_drain", 1'b0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
